// File: rtl/div_32.sv
// Sequential unsigned 32-bit restoring divider: one quotient bit per clock
// behind a start/done handshake, with divide-by-zero flagged in one cycle.
package div_32_pkg;
  localparam int unsigned WORDLEN = 32;
  localparam int unsigned CNT_W   = $clog2(WORDLEN);
endpackage

module div_32
  import div_32_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WORDLEN-1:0] dividend,
  input  logic [WORDLEN-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic [WORDLEN-1:0] quotient,
  output logic [WORDLEN-1:0] remainder,
  output logic               div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORDLEN-1:0] dvd_q, dvd_d;
  logic [WORDLEN-1:0] dvs_q, dvs_d;
  logic [WORDLEN-1:0] prem_q, prem_d;
  logic [WORDLEN-1:0] quot_d, rem_d;
  logic               dbz_d, busy_d, done_d;

  logic [WORDLEN:0]   trial;
  logic               trial_ge;
  logic [WORDLEN-1:0] step_rem;
  logic [WORDLEN-1:0] step_quo;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      quotient    <= quot_d;
      remainder   <= rem_d;
      div_by_zero <= dbz_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Next state, one restoring step, and registered-output next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quot_d  = quotient;
    rem_d   = remainder;
    dbz_d   = div_by_zero;

    // Extra top bit keeps the compare/subtract from overflowing
    trial    = {prem_q, dvd_q[WORDLEN-1]};
    trial_ge = (trial >= {1'b0, dvs_q});
    step_rem = trial_ge ? WORDLEN'(trial - {1'b0, dvs_q}) : trial[WORDLEN-1:0];
    step_quo = {dvd_q[WORDLEN-2:0], trial_ge};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            state_d = ST_CALC;
            dvd_d   = dividend;
            dvs_d   = divisor;
            prem_d  = '0;
            cnt_d   = CNT_W'(WORDLEN - 1);
          end else begin
            state_d = ST_DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      ST_CALC: begin
        prem_d = step_rem;
        dvd_d  = step_quo;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          quot_d  = step_quo;
          rem_d   = step_rem;
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_CALC);
    done_d = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_div_32.sv
// Self-checking bench for div_32: directed vector table, start re-pulse and
// mid-calculation reset sequences, then randomized pairs against / and %.
module tb_div_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_cmp = 0;
  int n_err = 0;

  div_32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation; reports result, Start-to-Done latency in cycles, busy cycles,
  // whether prior results held during the run, and whether Done stayed one cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int repulse_at,
                        output logic [31:0] q, output logic [31:0] r, output logic z,
                        output int lat, output int busy_cnt, output logic held,
                        output logic done_after);
    logic [31:0] q0, r0;
    logic        z0;
    @(negedge clk);
    q0 = quotient; r0 = remainder; z0 = div_by_zero;
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 1; busy_cnt = 0; held = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) held = 1'b0;
      if (lat == repulse_at) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    q = quotient; r = remainder; z = div_by_zero;
    @(negedge clk);
    done_after = done;
  endtask

  // Reference: plain arithmetic, all-ones quotient and pass-through remainder on /0
  task automatic apply_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input int repulse_at);
    logic [31:0] q, r, eq, er;
    logic        z, held, done_after;
    int          lat, bc;
    eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
    er = (b == 0) ? a : a % b;
    run_op(a, b, repulse_at, q, r, z, lat, bc, held, done_after);
    check({tag, " quotient"}, 64'(q), 64'(eq));
    check({tag, " remainder"}, 64'(r), 64'(er));
    check({tag, " div_by_zero"}, 64'(z), 64'(b == 0));
    check({tag, " latency"}, 64'(lat), 64'((b == 0) ? 1 : 33));
    check({tag, " busy_cycles"}, 64'(bc), 64'((b == 0) ? 0 : 32));
    check({tag, " hold"}, 64'(held), 64'(1));
    check({tag, " done_pulse"}, 64'(done_after), 64'(0));
    if (b != 0)
      check({tag, " identity"}, 64'(q) * 64'(b) + 64'(r) + 64'(r >= b), 64'(a));
  endtask

  initial begin
    logic [31:0] a, b;
    int          no_done;

    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,      1'b0};
    tbl[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,      1'b0};
    tbl[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,      1'b0};
    tbl[3] = '{32'd5,          32'd9,          32'd0,          32'd5,      1'b0};
    tbl[4] = '{32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,   1'b1};
    tbl[5] = '{32'd9,          32'd3,          32'd3,          32'd0,      1'b0};
    tbl[6] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,      1'b0};
    tbl[7] = '{32'd0,          32'd5,          32'd0,          32'd0,      1'b0};
    tbl[8] = '{32'd1,          32'hFFFF_FFFF,  32'd0,          32'd1,      1'b0};
    tbl[9] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,      1'b1};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    @(negedge clk);
    check("reset outputs", 64'({busy, done, div_by_zero, quotient, remainder}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table: stored expectations checked before the reference model is used
    for (int i = 0; i < 10; i++) begin
      logic [31:0] q, r;
      logic        z, held, done_after;
      int          lat, bc;
      run_op(tbl[i].a, tbl[i].b, -1, q, r, z, lat, bc, held, done_after);
      check($sformatf("tbl%0d quotient", i), 64'(q), 64'(tbl[i].q));
      check($sformatf("tbl%0d remainder", i), 64'(r), 64'(tbl[i].r));
      check($sformatf("tbl%0d div_by_zero", i), 64'(z), 64'(tbl[i].z));
      check($sformatf("tbl%0d latency", i), 64'(lat), 64'(tbl[i].z ? 1 : 33));
      check($sformatf("tbl%0d busy_cycles", i), 64'(bc), 64'(tbl[i].z ? 0 : 32));
      check($sformatf("tbl%0d done_pulse", i), 64'(done_after), 64'(0));
    end

    // Start re-pulsed with new operands mid-calculation must be ignored
    apply_and_check("repulse", 32'd100, 32'd7, 10);

    // Reset at cycle 15 of CALC: outputs clear at once and no Done follows
    @(negedge clk);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    check("abort busy before reset", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort outputs", 64'({busy, done, div_by_zero, quotient, remainder}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    no_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) no_done++;
    end
    check("abort no done", 64'(no_done), 64'(0));
    apply_and_check("after abort", 32'd1000, 32'd10, -1);

    // Randomized pairs across small, full-range and zero divisors
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = 32'($urandom_range(1, 15));
        4:       b = a >> $urandom_range(0, 31);
        5:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = a >> $urandom_range(0, 31);
      apply_and_check($sformatf("rnd%0d", i), a, b, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
